// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplication is shift-add on operand magnitudes and division is restoring
// shift-subtract on magnitudes. Both use one bit per enabled cycle, and the
// sign is fixed up in the cycle that enters DONE.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] prod_q, prod_d;     // {hi, lo}: product or {remainder, quotient}
    logic              neg_q, neg_d;       // negate the final value
    logic [XLEN-1:0]   result_q, result_d;

    // Accept-side decode: operand signedness, magnitudes, special cases
    logic            a_sgn, b_sgn, sa, sb;
    logic            div_zero, div_ovf, special, accept, last_iter;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    assign a_sgn = (op == 3'b000) | (op == 3'b001) | (op == 3'b010) |
                   (op == 3'b100) | (op == 3'b110);
    assign b_sgn = (op == 3'b000) | (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    assign sa    = a_sgn & a[XLEN-1];
    assign sb    = b_sgn & b[XLEN-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    assign div_zero    = op[2] & (b == '0);
    assign div_ovf     = op[2] & ~op[0] & (a == MIN_NEG) & (b == '1);
    assign special     = div_zero | div_ovf;
    assign special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    assign accept    = (state_q == IDLE) & start & enable & ~flush;
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    // One iteration of the datapath
    logic [XLEN:0]     add_sum, rem_sh, diff;
    logic [2*XLEN-1:0] mul_step, div_step, step, mul_full;
    logic [XLEN-1:0]   div_val, div_res, calc_res;

    assign add_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    assign mul_step = prod_q[0] ? {add_sum, prod_q[XLEN-1:1]}
                                : {1'b0, prod_q[2*XLEN-1:1]};

    // Remainder shifted left by one with the next dividend bit brought in.
    // A borrow in the top bit means the trial subtract must be discarded.
    assign rem_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, opnd_q};
    assign div_step = diff[XLEN] ? {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0],   prod_q[XLEN-2:0], 1'b1};

    assign step     = op_q[2] ? div_step : mul_step;
    assign mul_full = neg_q ? -step : step;
    assign div_val  = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    assign div_res  = neg_q ? -div_val : div_val;

    // Pick the architectural result from the final iteration
    always_comb begin
        calc_res = div_res;
        case (op_q)
            3'b000:                 calc_res = mul_full[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_res = mul_full[2*XLEN-1:XLEN];
            default:                calc_res = div_res;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: flush ignores enable, and every other move needs enable
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (enable) begin
            case (state_q)
                IDLE:    if (start) state_d = special ? DONE : CALC;
                CALC:    if (last_iter) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Status outputs decoded from state
    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q == CALC) | (state_q == DONE);
        done  = (state_q == DONE);
    end

    // Datapath next-state: load on accept, iterate in CALC, capture result on exit
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (accept) begin
            cnt_d = '0;
            if (special) begin
                result_d = special_res;
            end else begin
                op_d   = op;
                opnd_d = op[2] ? mag_b : mag_a;
                prod_d = {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
                neg_d  = (op[2] & op[1]) ? sa : (sa ^ sb);
            end
        end else if (!flush && enable && state_q == CALC) begin
            prod_d = step;
            cnt_d  = cnt_q + 1'b1;
            if (last_iter) begin
                cnt_d    = '0;
                result_d = calc_res;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, random ops against a
// plain-arithmetic model, and hand-written flush/reset/enable sequences.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset, enable, start, flush;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b;
    logic            ready, busy, done;
    logic [XLEN-1:0] result;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .op(op), .a(a), .b(b), .flush(flush),
        .ready(ready), .busy(busy), .done(done), .result(result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model computed with wide integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx, sy, ux;
        logic [63:0] t;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        case (f)
            3'd0: begin t = sx * sy; return t[31:0]; end
            3'd1: begin t = sx * sy; return t[63:32]; end
            3'd2: begin t = sx * longint'({32'b0, y}); return t[63:32]; end
            3'd3: begin t = {32'b0, x} * {32'b0, y}; return t[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                t = sx / sy; return t[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                t = sx % sy; return t[31:0];
            end
            default: begin
                if (y == 0) return x;
                t = ux % longint'({32'b0, y}); return t[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] x,
                                     input logic [31:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
        return XLEN + 1;
    endfunction

    // Issue one op. Enable is dropped for cycles [dis_from, dis_from+dis_len), and
    // a stray start with other operands is pulsed in cycle poke_at. lat is the cycle
    // after the accept edge in which done is seen, or 0 if the cycle budget expires.
    task automatic run(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input int dis_from, input int dis_len, input int poke_at,
                       output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clock);
        op = f; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0; bcnt = 0;
        for (int c = 1; c <= 100; c++) begin
            enable = !(c >= dis_from && c < dis_from + dis_len);
            start  = (c == poke_at);
            if (c == poke_at) begin op = 3'b000; a = 32'd9; b = 32'd9; end
            if (busy) bcnt++;
            if (done) begin lat = c; break; end
            tick();
        end
        start = 1'b0;
        enable = 1'b1;
        res = result;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] res, prev, x, y;
        logic [2:0]  f;
        int          lat, bcnt, r;
        bit          seen;

        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, 33};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        tbl[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        tbl[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};

        reset = 1'b1; enable = 1'b1; start = 1'b0; flush = 1'b0;
        op = '0; a = '0; b = '0;
        tick(); tick();
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        reset = 1'b0;
        tick();

        // Directed table
        foreach (tbl[i]) begin
            run(tbl[i].op, tbl[i].a, tbl[i].b, 0, 0, 0, res, lat, bcnt);
            chk($sformatf("tbl%0d_result", i), res, tbl[i].exp);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_busy_cycles", i), bcnt, tbl[i].lat);
            tick();
            chk($sformatf("tbl%0d_done_one_cycle", i), {ready, done}, 2'b10);
        end

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            x = $urandom; y = $urandom;
            r = $urandom_range(0, 7);
            if (r == 0) y = 32'h0;
            if (r == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (r == 2) y = 32'($urandom_range(1, 15));
            run(f, x, y, 0, 0, 0, res, lat, bcnt);
            chk($sformatf("rand%0d_op%0d_result", i, f), res, model(f, x, y));
            chk($sformatf("rand%0d_op%0d_latency", i, f), lat, model_lat(f, x, y));
            tick();
        end

        // flush and start together in IDLE: nothing accepted
        @(negedge clock);
        op = 3'd5; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_idle_ready", ready, 1);
        chk("flush_start_idle_busy", busy, 0);

        // flush at iteration 10 of DIV
        prev = result;
        @(negedge clock);
        op = 3'd4; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", ready, 1);
        chk("flush_done", done, 0);
        chk("flush_result_kept", result, prev);
        seen = 0;
        repeat (40) begin tick(); if (done) seen = 1; end
        chk("flush_no_done_pulse", seen, 0);

        // reset at iteration 5
        @(negedge clock);
        op = 3'd0; a = 32'd11; b = 32'd13; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_outputs", {ready, busy, done}, 3'b100);
        chk("midreset_result", result, 0);
        seen = 0;
        repeat (40) begin tick(); if (done) seen = 1; end
        chk("midreset_no_done_pulse", seen, 0);

        // enable low for 5 cycles mid-CALC, plus a stray start in CALC
        run(3'd5, 32'd1000, 32'd3, 11, 5, 5, res, lat, bcnt);
        chk("stall_result", res, 32'd333);
        chk("stall_latency", lat, 38);
        chk("stall_busy_cycles", bcnt, 38);

        // enable low while in DONE holds done; a start in DONE is ignored
        enable = 1'b0;
        tick();
        chk("done_hold_disabled", done, 1);
        enable = 1'b1;
        op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_exit", {ready, busy, done}, 3'b100);
        tick();
        chk("start_in_done_ignored", {ready, busy}, 2'b10);
        chk("start_in_done_result", result, 32'd333);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
